// File: rtl/multicore_result_collector_pkg.sv
// Shared constants, state encoding and index-width helper
// for the multicore result collection path.
package multicore_pkg;

    localparam int NUM_CORES_DEF = 61;
    localparam int DATA_W_DEF    = 32;

    typedef enum logic [1:0] {
        COLLECT_IDLE = 2'd0,
        COLLECT_RUN  = 2'd1,
        COLLECT_DONE = 2'd2
    } collect_state_t;

    // Index width for n cores, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicore_result_collector_if.sv
// Run control, flat per-core result buses and reduced result
// outputs of the collector.
interface multicore_result_collector_if
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = idx_w(NUM_CORES)
);

    logic                        start;
    logic [NUM_CORES-1:0]        core_en;
    logic [NUM_CORES*DATA_W-1:0] buf_val_1_s;
    logic [NUM_CORES*DATA_W-1:0] buf_val_2_s;
    logic [NUM_CORES-1:0]        buf_flag_s;
    logic                        busy;
    logic                        done;
    logic                        best_valid;
    logic [DATA_W-1:0]           best_val_1;
    logic [DATA_W-1:0]           best_val_2;
    logic [IDX_W-1:0]            best_core;
    logic [IDX_W:0]              serviced_cnt;

    modport master (
        output start, core_en, buf_val_1_s, buf_val_2_s, buf_flag_s,
        input  busy, done, best_valid, best_val_1, best_val_2,
        input  best_core, serviced_cnt
    );

    modport slave (
        input  start, core_en, buf_val_1_s, buf_val_2_s, buf_flag_s,
        output busy, done, best_valid, best_val_1, best_val_2,
        output best_core, serviced_cnt
    );

endinterface

// File: rtl/multicore_result_collector_encoder.sv
// Lowest-index-first priority encoder over the pending mask:
// one-hot grant, binary index and an any-request flag.
module lowest_pending_encoder #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] i_req,
    output logic [NUM_CORES-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicore_result_collector.sv
// Services flagged cores one per cycle and keeps the MIN or MAX
// val_1 result with its payload and core index.
module multicore_result_collector
    import multicore_pkg::*;
#(
    parameter int NUM_CORES  = NUM_CORES_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SELECT_MAX = 0
) (
    input  logic Clk,
    input  logic Reset,
    multicore_result_collector_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_CORES);

    collect_state_t       r_state;
    collect_state_t       w_state_next;
    logic [NUM_CORES-1:0] r_en_q;
    logic [NUM_CORES-1:0] r_serviced;
    logic                 r_best_valid;
    logic [DATA_W-1:0]    r_best_val_1;
    logic [DATA_W-1:0]    r_best_val_2;
    logic [IDX_W-1:0]     r_best_core;
    logic [IDX_W:0]       r_cnt;

    logic [NUM_CORES-1:0] w_pending;
    logic [NUM_CORES-1:0] w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic [DATA_W-1:0]    w_val_1;
    logic [DATA_W-1:0]    w_val_2;
    logic                 w_better;
    logic                 w_take;

    assign w_pending = bus.buf_flag_s & r_en_q & ~r_serviced;

    lowest_pending_encoder #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_enc (
        .i_req   (w_pending),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_val_1  = bus.buf_val_1_s[DATA_W*w_idx +: DATA_W];
    assign w_val_2  = bus.buf_val_2_s[DATA_W*w_idx +: DATA_W];
    // Strict compare: ties keep the incumbent (lower index).
    assign w_better = (SELECT_MAX != 0) ? (w_val_1 > r_best_val_1)
                                        : (w_val_1 < r_best_val_1);
    assign w_take   = (r_state == COLLECT_RUN) && w_any;

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= COLLECT_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state: start wins, run ends once every enabled core is serviced.
    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = COLLECT_RUN;
        end else begin
            case (r_state)
                COLLECT_IDLE: w_state_next = COLLECT_IDLE;
                COLLECT_RUN:  if (r_serviced == r_en_q)
                                  w_state_next = COLLECT_DONE;
                COLLECT_DONE: w_state_next = COLLECT_DONE;
                default:      w_state_next = COLLECT_IDLE;
            endcase
        end
    end

    // Collection state: cleared on start, updated on each servicing edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_en_q       <= '0;
            r_serviced   <= '0;
            r_best_valid <= 1'b0;
            r_best_val_1 <= '0;
            r_best_val_2 <= '0;
            r_best_core  <= '0;
            r_cnt        <= '0;
        end else if (bus.start) begin
            r_en_q       <= bus.core_en;
            r_serviced   <= '0;
            r_best_valid <= 1'b0;
            r_best_val_1 <= '0;
            r_best_val_2 <= '0;
            r_best_core  <= '0;
            r_cnt        <= '0;
        end else if (w_take) begin
            r_serviced <= r_serviced | w_grant;
            r_cnt      <= r_cnt + (IDX_W+1)'(1);
            if (!r_best_valid || w_better) begin
                r_best_valid <= 1'b1;
                r_best_val_1 <= w_val_1;
                r_best_val_2 <= w_val_2;
                r_best_core  <= w_idx;
            end
        end
    end

    assign bus.busy         = (r_state == COLLECT_RUN);
    assign bus.done         = (r_state == COLLECT_DONE);
    assign bus.best_valid   = r_best_valid;
    assign bus.best_val_1   = r_best_val_1;
    assign bus.best_val_2   = r_best_val_2;
    assign bus.best_core    = r_best_core;
    assign bus.serviced_cnt = r_cnt;

endmodule

// File: tb/tb_multicore_result_collector.sv
// Directed bench: MIN and MAX collectors (4 cores) share one
// stimulus stream; expected values are hand-derived.
module tb_multicore_result_collector;

    localparam int NC = 4;
    localparam int DW = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic          start = 1'b0;
    logic [NC-1:0] core_en = '0;
    logic [NC-1:0] flags = '0;
    logic [DW-1:0] v1 [NC];
    logic [DW-1:0] v2 [NC];
    logic [NC*DW-1:0] v1_s;
    logic [NC*DW-1:0] v2_s;

    int n_chk = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    multicore_result_collector_if #(.NUM_CORES(NC), .DATA_W(DW)) ifm ();
    multicore_result_collector_if #(.NUM_CORES(NC), .DATA_W(DW)) ifx ();

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            v1_s[DW*i +: DW] = v1[i];
            v2_s[DW*i +: DW] = v2[i];
        end
    end

    assign ifm.start = start;
    assign ifm.core_en = core_en;
    assign ifm.buf_flag_s = flags;
    assign ifm.buf_val_1_s = v1_s;
    assign ifm.buf_val_2_s = v2_s;
    assign ifx.start = start;
    assign ifx.core_en = core_en;
    assign ifx.buf_flag_s = flags;
    assign ifx.buf_val_1_s = v1_s;
    assign ifx.buf_val_2_s = v2_s;

    multicore_result_collector #(
        .NUM_CORES(NC), .DATA_W(DW), .SELECT_MAX(0)
    ) u_min (.Clk(Clk), .Reset(Reset), .bus(ifm.slave));

    multicore_result_collector #(
        .NUM_CORES(NC), .DATA_W(DW), .SELECT_MAX(1)
    ) u_max (.Clk(Clk), .Reset(Reset), .bus(ifx.slave));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start(input logic [NC-1:0] en);
        core_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_vals(input logic [DW-1:0] a0, a1, a2, a3);
        v1[0] = a0; v1[1] = a1; v1[2] = a2; v1[3] = a3;
        for (int i = 0; i < NC; i++) v2[i] = DW'(100 + i);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 64'(ifm.busy), 0);
        chk({tag, ".done"}, 64'(ifm.done), 0);
        chk({tag, ".valid"}, 64'(ifm.best_valid), 0);
        chk({tag, ".v1"}, 64'(ifm.best_val_1), 0);
        chk({tag, ".v2"}, 64'(ifm.best_val_2), 0);
        chk({tag, ".core"}, 64'(ifm.best_core), 0);
        chk({tag, ".cnt"}, 64'(ifm.serviced_cnt), 0);
        chk({tag, ".xbusy"}, 64'(ifx.busy), 0);
        chk({tag, ".xcnt"}, 64'(ifx.serviced_cnt), 0);
    endtask

    initial begin
        set_vals(9, 3, 7, 3);
        repeat (3) tick();
        chk_zero("rst");
        Reset = 1'b1;
        tick();
        // Flags toggling while idle must not be collected.
        for (int k = 0; k < 4; k++) begin
            flags = (k % 2 == 0) ? 4'b1111 : 4'b0101;
            tick();
        end
        chk_zero("idle");

        // All four enabled and flagged: MIN -> core1, MAX -> core0.
        flags = 4'b1111;
        pulse_start(4'b1111);
        chk("run.busy", 64'(ifm.busy), 1);
        chk("run.cnt0", 64'(ifm.serviced_cnt), 0);
        tick();
        chk("run.cnt1", 64'(ifm.serviced_cnt), 1);
        chk("run.core1", 64'(ifm.best_core), 0);
        tick();
        chk("run.min2", 64'(ifm.best_core), 1);
        chk("run.max2", 64'(ifx.best_core), 0);
        tick();
        tick();
        chk("run.cnt4", 64'(ifm.serviced_cnt), 4);
        chk("run.done4", 64'(ifm.done), 0);
        tick();
        chk("run.done", 64'(ifm.done), 1);
        chk("run.busyd", 64'(ifm.busy), 0);
        chk("min.core", 64'(ifm.best_core), 1);
        chk("min.v1", 64'(ifm.best_val_1), 3);
        chk("min.v2", 64'(ifm.best_val_2), 101);
        chk("min.valid", 64'(ifm.best_valid), 1);
        chk("max.core", 64'(ifx.best_core), 0);
        chk("max.v1", 64'(ifx.best_val_1), 9);
        chk("max.v2", 64'(ifx.best_val_2), 100);
        chk("max.done", 64'(ifx.done), 1);
        flags = 4'b0000;
        tick();
        flags = 4'b1111;
        tick();
        chk("hold.cnt", 64'(ifm.serviced_cnt), 4);
        chk("hold.v1", 64'(ifm.best_val_1), 3);
        chk("hold.done", 64'(ifm.done), 1);

        // Mask 1010: core 3 then core 1, ten cycles apart.
        flags = 4'b0000;
        set_vals(9, 5, 7, 2);
        pulse_start(4'b1010);
        repeat (3) tick();
        chk("msk.cnt0", 64'(ifm.serviced_cnt), 0);
        flags[3] = 1'b1;
        tick();
        chk("msk.cnt1", 64'(ifm.serviced_cnt), 1);
        chk("msk.core3", 64'(ifm.best_core), 3);
        chk("msk.v1", 64'(ifm.best_val_1), 2);
        flags[0] = 1'b1;
        repeat (9) tick();
        chk("msk.wait", 64'(ifm.serviced_cnt), 1);
        flags[1] = 1'b1;
        tick();
        chk("msk.cnt2", 64'(ifm.serviced_cnt), 2);
        chk("msk.notdone", 64'(ifm.done), 0);
        chk("msk.min", 64'(ifm.best_core), 3);
        chk("msk.max", 64'(ifx.best_core), 1);
        chk("msk.maxv", 64'(ifx.best_val_1), 5);
        tick();
        chk("msk.done", 64'(ifm.done), 1);
        repeat (2) tick();
        chk("msk.final", 64'(ifm.serviced_cnt), 2);

        // Empty mask.
        pulse_start(4'b0000);
        chk("emp.busy", 64'(ifm.busy), 1);
        tick();
        chk("emp.done", 64'(ifm.done), 1);
        chk("emp.valid", 64'(ifm.best_valid), 0);
        chk("emp.cnt", 64'(ifm.serviced_cnt), 0);

        // Restart mid-collect after two services.
        set_vals(9, 3, 7, 3);
        flags = 4'b1111;
        pulse_start(4'b1111);
        tick();
        tick();
        chk("rs.cnt2", 64'(ifm.serviced_cnt), 2);
        pulse_start(4'b0100);
        chk("rs.cnt0", 64'(ifm.serviced_cnt), 0);
        chk("rs.valid", 64'(ifm.best_valid), 0);
        chk("rs.busy", 64'(ifm.busy), 1);
        tick();
        chk("rs.cnt1", 64'(ifm.serviced_cnt), 1);
        chk("rs.core", 64'(ifm.best_core), 2);
        chk("rs.v1", 64'(ifm.best_val_1), 7);
        tick();
        chk("rs.done", 64'(ifm.done), 1);

        // Asynchronous reset mid-collect.
        pulse_start(4'b1111);
        tick();
        #2;
        Reset = 1'b0;
        #1;
        chk_zero("arst");
        tick();
        Reset = 1'b1;
        tick();
        chk_zero("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
